// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory slave for the core's load/store port.
// One request at a time over valid/ready. Each request sees a fixed LATENCY,
// then a response that is held until it is accepted.
// Optional macro DMEM_STRB_EN: when defined, req_wstrb selects the byte lanes
// that a store writes. When undefined, every store writes the full word.
module dmem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic        lat_write;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [3:0]  eff_strb;
  logic [31:0] mem [DEPTH];

  logic        accept, access, acc_err;
  logic [29:0] word_idx;
  logic [AW-1:0] mem_idx;

  assign accept   = (state == IDLE) && req_valid;
  assign access   = (state == BUSY) && (cnt == 4'd0);
  assign word_idx = lat_addr[31:2];
  assign mem_idx  = word_idx[AW-1:0];
  assign acc_err  = (lat_addr[1:0] != 2'b00) || ({2'b00, word_idx} >= 32'(DEPTH));

`ifdef DMEM_STRB_EN
  logic [3:0] lat_wstrb;

  // Capture the byte strobes alongside the rest of the request.
  always_ff @(posedge clk or posedge reset)
    if (reset)       lat_wstrb <= 4'h0;
    else if (accept) lat_wstrb <= req_wstrb;

  assign eff_strb = lat_wstrb;
`else
  // Strobes are ignored in this build; every store is a full-word write.
  logic strb_unused;
  assign strb_unused = ^req_wstrb;
  assign eff_strb    = 4'hF;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else       state <= state_nxt;

  // Next-state logic and handshake outputs.
  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = BUSY;
      end
      BUSY: if (cnt == 4'd0) state_nxt = RESP;
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch, latency counter and held response.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt        <= 4'd0;
      lat_write  <= 1'b0;
      lat_addr   <= 32'h0;
      lat_wdata  <= 32'h0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
    end else begin
      if (accept) begin
        lat_write <= req_write;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        cnt       <= 4'(LATENCY - 1);
      end else if (state == BUSY && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (access) begin
        resp_err   <= acc_err;
        resp_rdata <= (acc_err || lat_write) ? 32'h0 : mem[mem_idx];
      end else if (state == RESP && resp_ready) begin
        resp_err   <= 1'b0;
        resp_rdata <= 32'h0;
      end
    end

  // Array write on the access edge. A reset in BUSY forces state to IDLE,
  // so an aborted store never reaches this point.
  always_ff @(posedge clk)
    if (access && lat_write && !acc_err)
      for (int b = 0; b < 4; b++)
        if (eff_strb[b]) mem[mem_idx][8*b +: 8] <= lat_wdata[8*b +: 8];

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder. The driver pushes expected responses
// computed from a word-array model. A monitor pops and compares them when
// responses appear.
module tb_dmem_responder;
  localparam int DEPTH   = 1024;
  localparam int LATENCY = 2;
`ifdef DMEM_STRB_EN
  localparam bit STRB = 1'b1;
`else
  localparam bit STRB = 1'b0;
`endif

  logic        clk = 0, reset = 1;
  logic        req_valid = 0, req_write = 0, resp_ready = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic [3:0]  req_wstrb = 0;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_wstrb(req_wstrb), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mdl[int];
  int          cyc = 0;
  int          checks = 0, errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a word array updated by bytes.
  task automatic model(input bit wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input bit commit, output exp_t e);
    int idx;
    logic [3:0] st;
    idx     = int'(a >> 2);
    e.err   = (a % 4 != 0) || (a / 4 >= DEPTH);
    e.rdata = 32'h0;
    e.acc   = 0;
    st      = STRB ? s : 4'hF;
    if (!e.err) begin
      if (wr) begin
        if (commit)
          for (int b = 0; b < 4; b++)
            if (st[b]) begin
              logic [31:0] w;
              w = mdl.exists(idx) ? mdl[idx] : 32'h0;
              w[8*b +: 8] = d[8*b +: 8];
              mdl[idx] = w;
            end
      end else begin
        e.rdata = mdl.exists(idx) ? mdl[idx] : 32'hx;
      end
    end
  endtask

  // Monitor: match each new response against the scoreboard, then check it stays put.
  exp_t cur;
  bit   active = 0;
  always @(negedge clk) begin
    if (reset) active = 0;
    else if (resp_valid && !active) begin
      active = 1;
      if (sb.size() == 0) begin
        errors++; checks++;
        $display("FAIL unexpected_resp: got rdata %h with empty scoreboard", resp_rdata);
        cur.rdata = resp_rdata; cur.err = resp_err; cur.acc = cyc - LATENCY;
      end else begin
        cur = sb.pop_front();
        chk("latency", 32'(cyc - cur.acc), 32'(LATENCY));
        chk("rdata", resp_rdata, cur.rdata);
        chk("err", {31'b0, resp_err}, {31'b0, cur.err});
      end
      chk("req_ready_in_resp", {31'b0, req_ready}, 32'h0);
    end else if (resp_valid && active) begin
      chk("rdata_hold", resp_rdata, cur.rdata);
      chk("err_hold", {31'b0, resp_err}, {31'b0, cur.err});
      chk("req_ready_in_resp", {31'b0, req_ready}, 32'h0);
    end else if (!resp_valid && active) begin
      active = 0;
      chk("req_ready_after_resp", {31'b0, req_ready}, 32'h1);
      chk("rdata_cleared", resp_rdata, 32'h0);
    end
  end

  // Issue one request. rdly is the number of cycles before resp_ready rises.
  task automatic do_req(input bit wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input int rdly);
    exp_t e;
    int   n;
    @(negedge clk);
    req_valid = 1; req_write = wr; req_addr = a; req_wdata = d; req_wstrb = s;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (!req_ready) begin
      errors++; checks++;
      $display("FAIL req_ready_timeout: got 0 expected 1");
    end
    @(posedge clk); #1;
    model(wr, a, d, s, 1'b1, e);
    e.acc = cyc;
    sb.push_back(e);
    // Scramble request inputs; they must no longer matter.
    req_valid = 0; req_write = 1'($urandom); req_addr = $urandom;
    req_wdata = $urandom; req_wstrb = 4'($urandom);
    repeat (rdly) @(negedge clk);
    @(negedge clk);
    resp_ready = 1;
    n = 0;
    while (!resp_valid && n < 50) begin @(negedge clk); n++; end
    if (!resp_valid) begin
      errors++; checks++;
      $display("FAIL resp_timeout: got resp_valid 0 expected 1");
    end
    @(posedge clk); #1;
    resp_ready = 0;
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 8)      return 32'($urandom_range(0, 15) * 4);
    else if (r < 9) return 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
    else            return 32'(DEPTH * 4 + $urandom_range(0, 255) * 4);
  endfunction

  initial begin
    // Reset values.
    #12;
    chk("rst_req_ready", {31'b0, req_ready}, 32'h1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_err", {31'b0, resp_err}, 32'h0);
    @(negedge clk); reset = 0;

    // Give every word used below a known value.
    for (int i = 0; i < 16; i++) do_req(1, 32'(i * 4), $urandom, 4'hF, 0);

    // Store then load.
    do_req(1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
    do_req(0, 32'h10, 32'h0, 4'h0, 0);
    // Misaligned load, then the prior word is intact.
    do_req(0, 32'h12, 32'h0, 4'h0, 1);
    do_req(0, 32'h10, 32'h0, 4'h0, 0);
    // Out-of-range store, then word 0 is unchanged.
    do_req(1, 32'h1000, 32'hCAFEF00D, 4'hF, 0);
    do_req(0, 32'h0, 32'h0, 4'h0, 0);
    // Partial-strobe merge.
    do_req(1, 32'h18, 32'h11223344, 4'hF, 0);
    do_req(1, 32'h18, 32'hAABBCCDD, 4'b0101, 0);
    do_req(0, 32'h18, 32'h0, 4'h0, 0);
    chk("strb_merge", mdl[6], STRB ? 32'h11BB33DD : 32'hAABBCCDD);
    // Store with no strobes.
    do_req(1, 32'h18, 32'h0, 4'h0, 0);
    do_req(0, 32'h18, 32'h0, 4'h0, 0);
    // Back-pressure: hold the response for 5 cycles.
    do_req(0, 32'h10, 32'h0, 4'h0, 5);

    // Reset during BUSY of a store aborts it.
    do_req(1, 32'h20, 32'h5, 4'hF, 0);
    @(negedge clk);
    req_valid = 1; req_write = 1; req_addr = 32'h20; req_wdata = 32'h99; req_wstrb = 4'hF;
    @(posedge clk); #1;
    req_valid = 0;
    reset = 1; #1;
    chk("abort_req_ready", {31'b0, req_ready}, 32'h1);
    chk("abort_resp_valid", {31'b0, resp_valid}, 32'h0);
    chk("abort_rdata", resp_rdata, 32'h0);
    chk("abort_err", {31'b0, resp_err}, 32'h0);
    @(negedge clk); @(negedge clk); reset = 0;
    do_req(0, 32'h20, 32'h0, 4'h0, 0);
    chk("abort_model", mdl[8], 32'h5);

    // Randomized traffic.
    for (int t = 0; t < 300; t++)
      do_req(1'($urandom), rand_addr(), $urandom, 4'($urandom), $urandom_range(0, 3));

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Multi-cycle data-memory responder: the slave end of the CPU's load/store request interface.
- Accepts one word-granular read or write request at a time over a valid/ready handshake and models a fixed access latency.
- Returns read data or a write acknowledgement over a valid/ready response channel.
- Replaces the single-cycle data memory once the core is pipelined or multi-cycle.

Parameters:
- DEPTH, 1024, number of 32-bit words in the internal array.
- LATENCY, 2, cycles from request acceptance to resp_valid; legal range 1..15.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data.
- req_wstrb  input  4  byte write strobes; bit i covers bits [8i+7:8i].
- resp_valid  output  1  response present.
- resp_ready  input  1  initiator accepts the response.
- resp_rdata  output  32  load data; 0 for stores and errors.
- resp_err  output  1  access fault.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous, active-high and named reset.
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, latency counter=0. Array contents are not reset.
- IDLE state:
  - req_ready=1.
  - On a rising edge with req_valid & req_ready, latch write, addr, wdata and wstrb.
  - Load the counter with LATENCY-1 and go to BUSY.
- BUSY state:
  - req_ready=0; the counter decrements each cycle.
  - At the edge where the counter equals 0, perform the access and go to RESP.
  - With LATENCY=1, BUSY lasts exactly one cycle.
- Access rules:
  - Word index = addr[31:2].
  - Error if addr[1:0]!=0 or index>=DEPTH. On error: no array update, resp_err=1, resp_rdata=0.
  - Load: resp_rdata = array[index].
  - Store: each byte lane with a set wstrb bit is written; resp_rdata=0.
- RESP state:
  - resp_valid=1, req_ready=0.
  - resp_rdata and resp_err stay stable until resp_valid & resp_ready at a rising edge.
  - On that handshake go to IDLE and clear resp_valid, resp_rdata and resp_err.
- Latency: a request accepted at edge T produces resp_valid high after edge T+LATENCY. Minimum round trip is LATENCY+1 cycles including the response handshake.
- One outstanding request only. req_valid during BUSY/RESP is ignored; the initiator must hold it.
- Store visibility: a store completed in one transaction is visible to a load issued in the next transaction.
- Reset mid-operation: reset asserted in BUSY aborts the transaction and no array write occurs. Reset in RESP drops the response, and any store has already been committed.
- Store with wstrb=0: completes normally with no byte changed and resp_err=0.
- Request inputs are sampled only at the acceptance edge. Later changes on the request inputs have no effect.

Optional Feature:
- Macro: DMEM_STRB_EN.
- Defined: req_wstrb is honoured as specified above.
- Not defined: req_wstrb is ignored and every store writes the full word (treated as 4'hF). Loads are unaffected.

Test Plan:
- LATENCY=2, store addr 0x10 data 0xDEADBEEF strb F, then load 0x10:
  - store: resp_valid 2 cycles after acceptance, err=0, rdata=0;
  - load: returns 0xDEADBEEF.
- Load addr 0x12 (misaligned): resp_err=1, resp_rdata=0. A following load of 0x10 still returns the prior word.
- DEPTH=1024, store to 0x1000: resp_err=1, and the array is unchanged (check by a load of 0x0).
- Store 0x11223344 strb F, then 0xAABBCCDD strb 4'b0101, then load:
  - DMEM_STRB_EN defined: 0x11BB33DD;
  - not defined: 0xAABBCCDD.
- Hold resp_ready=0 for 5 cycles: resp_valid and resp_rdata stay stable and req_ready stays 0. Assert resp_ready: the next cycle is IDLE with req_ready=1.
- Assert reset during BUSY of a store to 0x20 (after a prior word 0x5 was stored there): outputs return to reset values immediately, and a later load of 0x20 returns 0x5.
